// File: rtl/memShare_config_pkg.sv
// Shared configuration for the message-pass buffer: address/table sizing,
// burst length and the read-address generator state encoding.
package memShare_config_pkg;

  localparam int MSGPASS_RD_ADDR_WIDTH = 8;
  localparam int MSGPASS_BASEADDR_NUM  = 4;
  localparam int MSGPASS_BURST_LEN     = 4;

  typedef logic [MSGPASS_RD_ADDR_WIDTH-1:0]         msgpass_addr_t;
  typedef logic [$clog2(MSGPASS_BASEADDR_NUM)-1:0]  msgpass_layer_idx_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } msgpass_agen_state_e;

endpackage

// File: rtl/msgpass_base_table.sv
// Per-layer base-address register file: one write port, asynchronous read by index.
// Writes land on the clock edge; contents clear on reset.
module msgpass_base_table #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_NUM   = 4,
  localparam int IDX_W     = $clog2(BASE_NUM)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [ADDR_WIDTH-1:0] wr_base_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [ADDR_WIDTH-1:0] rd_base_o
);

  logic [ADDR_WIDTH-1:0] table_q [BASE_NUM];
  logic [ADDR_WIDTH-1:0] table_d [BASE_NUM];

  always_comb begin
    table_d = table_q;
    if (we_i && (int'(wr_idx_i) < BASE_NUM)) begin
      table_d[wr_idx_i] = wr_base_i;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BASE_NUM; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      table_q <= table_d;
    end
  end

  // Out-of-range indices (non power-of-two BASE_NUM) read as zero.
  assign rd_base_o = (int'(rd_idx_i) < BASE_NUM) ? table_q[rd_idx_i] : '0;

endmodule

// File: rtl/msgpass_rd_addr_gen.sv
// Burst read-address generator: start -> first beat after 1 cycle, registered outputs held under rd_ready_i=0.
// Optional sticky overflow flag ovf_err_o when MSGPASS_ADDR_BOUND_CHK_EN is defined.
module msgpass_rd_addr_gen
  import memShare_config_pkg::*;
#(
  parameter int ADDR_WIDTH = MSGPASS_RD_ADDR_WIDTH,
  parameter int BASE_NUM   = MSGPASS_BASEADDR_NUM,
  parameter int BURST_LEN  = MSGPASS_BURST_LEN,
  parameter int STRIDE     = 1,
  localparam int IDX_W     = $clog2(BASE_NUM)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic                  start_i,
  input  logic [IDX_W-1:0]      layer_sel_i,
  input  logic                  auto_layer_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  last_o,
  output logic                  busy_o,
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
  output logic                  ovf_err_o,
`endif
  output logic                  iter_done_o
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
  localparam int SUM_W  = ADDR_WIDTH + 32;
`else
  localparam int SUM_W  = ADDR_WIDTH;
`endif
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_LAYER = IDX_W'(BASE_NUM - 1);

  msgpass_agen_state_e    state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [IDX_W-1:0]       layer_cnt_q, layer_cnt_d;
  logic                   auto_q, auto_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   iter_done_q, iter_done_d;
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
  logic                   ovf_q, ovf_d;
`endif

  logic [IDX_W-1:0]       table_idx;
  logic [ADDR_WIDTH-1:0]  table_base;
  logic [SUM_W-1:0]       sum;

  assign table_idx = auto_layer_i ? layer_cnt_q : layer_sel_i;

  msgpass_base_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_NUM   (BASE_NUM)
  ) u_base_table (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .we_i      (cfg_we_i),
    .wr_idx_i  (cfg_idx_i),
    .wr_base_i (cfg_base_i),
    .rd_idx_i  (table_idx),
    .rd_base_o (table_base)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    beat_d      = beat_q;
    layer_cnt_d = layer_cnt_q;
    auto_d      = auto_q;
    rd_addr_d   = rd_addr_q;
    rd_valid_d  = rd_valid_q;
    last_d      = last_q;
    busy_d      = busy_q;
    iter_done_d = 1'b0;
    sum         = '0;
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        // Base is latched here, so a same-cycle table write only affects later bursts.
        if (start_i) begin
          state_d    = ISSUE;
          base_d     = table_base;
          auto_d     = auto_layer_i;
          beat_d     = '0;
          rd_addr_d  = table_base;
          rd_valid_d = 1'b1;
          busy_d     = 1'b1;
          last_d     = (LAST_BEAT == '0);
        end
      end
      ISSUE: begin
        if (rd_valid_q && rd_ready_i) begin
          if (last_q) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            if (auto_q) begin
              if (layer_cnt_q == LAST_LAYER) begin
                layer_cnt_d = '0;
                iter_done_d = 1'b1;
              end else begin
                layer_cnt_d = layer_cnt_q + 1'b1;
              end
            end
          end else begin
            beat_d    = beat_q + 1'b1;
            sum       = SUM_W'(base_q) + SUM_W'(beat_d) * SUM_W'(STRIDE);
            rd_addr_d = sum[ADDR_WIDTH-1:0];
            last_d    = (beat_d == LAST_BEAT);
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
            ovf_d     = ovf_q | (|sum[SUM_W-1:ADDR_WIDTH]);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      beat_q      <= '0;
      layer_cnt_q <= '0;
      auto_q      <= 1'b0;
      rd_addr_q   <= '0;
      rd_valid_q  <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      iter_done_q <= 1'b0;
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      layer_cnt_q <= layer_cnt_d;
      auto_q      <= auto_d;
      rd_addr_q   <= rd_addr_d;
      rd_valid_q  <= rd_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      iter_done_q <= iter_done_d;
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign rd_valid_o  = rd_valid_q;
  assign last_o      = last_q;
  assign busy_o      = busy_q;
  assign iter_done_o = iter_done_q;
`ifdef MSGPASS_ADDR_BOUND_CHK_EN
  assign ovf_err_o   = ovf_q;
`endif

endmodule

// File: doc/msgpass_rd_addr_gen.md
Name: msgpass_rd_addr_gen

Overview:
- Parametrised read-address generator for the message-pass buffer. Replaces the fixed-zero dummy base address.
- Holds a programmable table of base addresses, one per layer.
- On each start request it issues a burst of sequential read addresses (base + offset) over a valid/ready handshake.
- Sits between the layer scheduler and the message-pass buffer read port, feeding the SCU.memShare() target region.

Parameters:
- ADDR_WIDTH, memShare_config_pkg::MSGPASS_RD_ADDR_WIDTH, width of read/base addresses.
- BASE_NUM, memShare_config_pkg::MSGPASS_BASEADDR_NUM, number of base-table entries (layers), >=2.
- BURST_LEN, 4, addresses issued per burst, >=1.
- STRIDE, 1, address increment between beats, >=1.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we_i  in  1  base-table write enable.
- cfg_idx_i  in  $clog2(BASE_NUM)  base-table write index.
- cfg_base_i  in  ADDR_WIDTH  base value to write.
- start_i  in  1  single-cycle burst request; accepted only when busy_o=0.
- layer_sel_i  in  $clog2(BASE_NUM)  layer for this burst; sampled with start_i.
- auto_layer_i  in  1  1: ignore layer_sel_i and use the internal layer counter.
- rd_addr_o  out  ADDR_WIDTH  read address.
- rd_valid_o  out  1  rd_addr_o valid.
- rd_ready_i  in  1  downstream accepts the address.
- last_o  out  1  marks the final beat of a burst (qualified by rd_valid_o).
- busy_o  out  1  burst in progress.
- iter_done_o  out  1  one-cycle pulse when the auto layer counter wraps BASE_NUM-1 -> 0.

Behaviour:
- Reset (async assert, sync release): base table all 0; state IDLE; rd_addr_o=0, rd_valid_o=0, last_o=0, busy_o=0, iter_done_o=0; layer counter 0; beat counter 0.
- Base table: written on a cfg_we_i clock edge. A same-cycle write to the layer being started takes effect for the next burst only, because the base is latched on start.
- FSM states:
  - IDLE: start_i=1 latches base = table[auto_layer_i ? layer_cnt : layer_sel_i], clears beat counter, goes to ISSUE. rd_valid_o rises on the next cycle (latency 1).
  - ISSUE: rd_addr_o = base + beat*STRIDE, truncated to ADDR_WIDTH (modulo 2^ADDR_WIDTH wrap). Outputs are registered and held stable while rd_ready_i=0. Beat counter advances only on rd_valid_o && rd_ready_i. last_o=1 when beat==BURST_LEN-1. Handshake on the last beat goes to IDLE: rd_valid_o drops the next cycle.
  - When auto_layer_i was 1 at start: layer_cnt increments on the last handshake, wrapping BASE_NUM-1 -> 0. On the wrap, iter_done_o pulses in the same cycle rd_valid_o drops.
- busy_o=1 from the cycle after start acceptance through the last handshake. start_i while busy_o=1 is ignored (no queueing).
- Back-to-back bursts: start_i may be asserted in the cycle after the last handshake. Minimum gap is 1 idle cycle.
- BURST_LEN=1: a single beat with last_o=1.
- rst mid-burst: immediate abort, all outputs return to reset values, base table cleared.

Optional Feature:
- Macro: MSGPASS_ADDR_BOUND_CHK_EN.
- Defined: adds output ovf_err_o (1 bit, reset 0). It sets sticky when any issued address's untruncated sum exceeds 2^ADDR_WIDTH-1, and clears only on rst. Addresses still wrap.
- Undefined: no port, no check logic; addresses wrap silently.

Decomposition:
- memShare_config_pkg (shared package):
  - existing MSGPASS_RD_ADDR_WIDTH and MSGPASS_BASEADDR_NUM.
  - new MSGPASS_BURST_LEN.
  - typedef msgpass_addr_t.
  - typedef msgpass_layer_idx_t.
  - enum msgpass_agen_state_e {IDLE, ISSUE}.
- One natural sub-module: msgpass_base_table, the register file with write port and asynchronous read by index.

Test Plan:
- Program table[0]=0x10, table[1]=0x40. start_i with layer_sel_i=1, BURST_LEN=4, rd_ready_i=1 -> rd_addr_o 0x40,0x41,0x42,0x43 on consecutive cycles; last_o on 0x43; busy_o drops afterwards.
- Same burst with rd_ready_i low on cycles 2-3 -> rd_addr_o held at 0x41 with rd_valid_o=1; total 4 handshakes, no address skipped or repeated.
- auto_layer_i=1, BASE_NUM=4, 4 consecutive bursts -> bases 0,1,2,3 in order; iter_done_o pulses exactly once after the 4th burst; the 5th burst uses layer 0.
- ADDR_WIDTH=8, table[0]=0xFE, STRIDE=1, BURST_LEN=4 -> addresses 0xFE,0xFF,0x00,0x01; with MSGPASS_ADDR_BOUND_CHK_EN, ovf_err_o=1 from the 0x00 beat onward.
- start_i during busy_o=1 -> ignored, with no extra beats. cfg write to table[1]=0x80 during an active layer-1 burst -> current burst keeps 0x40, next burst starts at 0x80.
- Assert rst during beat 2 -> rd_valid_o, busy_o, last_o go to 0 immediately, without waiting for a clock edge; after release, a layer-1 start yields base 0x00 because the table was cleared.
